// File: rtl/lii_in_unpack_fifo.sv
// Receive-side unpacker: filters 512-bit LII beats by destination ID and splits
// accepted beats into two independently drained first-word-fall-through FIFOs.
module lii_in_unpack_fifo #(
    parameter int          PW       = 512,
    parameter int          SW       = 256,
    parameter int          DEPTH    = 4,
    parameter logic [7:0]  LOCAL_ID = 8'h01
) (
    input  logic          aclk,
    input  logic          arstn,
    input  logic [PW-1:0] lii_in_p0_tdata,
    input  logic          lii_in_p0_tvalid,
    output logic          lii_in_p0_tready,
    input  logic [7:0]    lii_in_p0_src,
    input  logic [7:0]    lii_in_p0_dst,
    output logic [SW-1:0] training_stream_tdata,
    output logic          training_stream_tvalid,
    input  logic          training_stream_tready,
    output logic [SW-1:0] test_stream_tdata,
    output logic          test_stream_tvalid,
    input  logic          test_stream_tready,
    output logic [7:0]    last_src,
    output logic [15:0]   drop_cnt,
    output logic          ce
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [SW-1:0] mem_a_q [DEPTH];
    logic [SW-1:0] mem_a_d [DEPTH];
    logic [SW-1:0] mem_b_q [DEPTH];
    logic [SW-1:0] mem_b_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_a_q, rptr_a_d;
    logic [AW-1:0] rptr_b_q, rptr_b_d;
    logic [AW:0]   cnt_a_q, cnt_a_d;
    logic [AW:0]   cnt_b_q, cnt_b_d;
    logic          tready_q, tready_d;
    logic [7:0]    last_src_q, last_src_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          accept_s;
    logic          push_s;
    logic          drop_s;
    logic          pop_a_s;
    logic          pop_b_s;

    // Next-state logic for both FIFOs, the ready flag and the status registers.
    always_comb begin
        mem_a_d    = mem_a_q;
        mem_b_d    = mem_b_q;
        wptr_d     = wptr_q;
        rptr_a_d   = rptr_a_q;
        rptr_b_d   = rptr_b_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        last_src_d = last_src_q;
        drop_cnt_d = drop_cnt_q;

        accept_s = lii_in_p0_tvalid & tready_q;
        push_s   = accept_s & (lii_in_p0_dst == LOCAL_ID);
        drop_s   = accept_s & (lii_in_p0_dst != LOCAL_ID);
        pop_a_s  = (cnt_a_q != '0) & training_stream_tready;
        pop_b_s  = (cnt_b_q != '0) & test_stream_tready;

        // Both halves share one write pointer because they are always pushed together.
        if (push_s) begin
            mem_a_d[wptr_q] = lii_in_p0_tdata[PW-1:SW];
            mem_b_d[wptr_q] = lii_in_p0_tdata[SW-1:0];
            wptr_d          = wptr_q + AW'(1);
            last_src_d      = lii_in_p0_src;
        end else begin
            wptr_d          = wptr_q;
            last_src_d      = last_src_q;
        end

        if (pop_a_s) begin
            rptr_a_d = rptr_a_q + AW'(1);
        end else begin
            rptr_a_d = rptr_a_q;
        end

        if (pop_b_s) begin
            rptr_b_d = rptr_b_q + AW'(1);
        end else begin
            rptr_b_d = rptr_b_q;
        end

        case ({push_s, pop_a_s})
            2'b10:   cnt_a_d = cnt_a_q + (AW+1)'(1);
            2'b01:   cnt_a_d = cnt_a_q - (AW+1)'(1);
            default: cnt_a_d = cnt_a_q;
        endcase

        case ({push_s, pop_b_s})
            2'b10:   cnt_b_d = cnt_b_q + (AW+1)'(1);
            2'b01:   cnt_b_d = cnt_b_q - (AW+1)'(1);
            default: cnt_b_d = cnt_b_q;
        endcase

        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        // Ready reflects occupancy only; a pop in the same cycle never bypasses a full FIFO.
        tready_d = (cnt_a_d < FULL_CNT) & (cnt_b_d < FULL_CNT);
    end

    // State registers; reset clears all storage so outputs are never X.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_a_q   <= '0;
            rptr_b_q   <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            tready_q   <= 1'b0;
            last_src_q <= 8'h00;
            drop_cnt_q <= 16'h0000;
        end else begin
            mem_a_q    <= mem_a_d;
            mem_b_q    <= mem_b_d;
            wptr_q     <= wptr_d;
            rptr_a_q   <= rptr_a_d;
            rptr_b_q   <= rptr_b_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            tready_q   <= tready_d;
            last_src_q <= last_src_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign lii_in_p0_tready       = tready_q;
    assign training_stream_tdata  = mem_a_q[rptr_a_q];
    assign training_stream_tvalid = (cnt_a_q != '0);
    assign test_stream_tdata      = mem_b_q[rptr_b_q];
    assign test_stream_tvalid     = (cnt_b_q != '0);
    assign last_src               = last_src_q;
    assign drop_cnt               = drop_cnt_q;
    assign ce = training_stream_tvalid & test_stream_tvalid &
                training_stream_tready & test_stream_tready;

endmodule
